// File: rtl/fetch_unit_pkg.sv
// Shared defaults for the instruction-fetch front end and its queue.
// The datapath and controlBlock pick up the same address/instruction widths from here.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned RESET_PC_DEF = 0;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {instr, pc} entries between memory and decode.
// Push and pop may both happen in one cycle at any occupancy; flush empties it in one edge.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_W_DEF + ADDR_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues in-order word fetches, buffers responses,
// hands {instr, pc} to decode, and discards in-flight work on a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  // Both ports use plain valid/ready: a transfer happens on any rising edge where
  // valid and ready are both high; valid never depends on ready of the same port.

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned QW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     q_count;
  logic [CW:0]       credits;
  logic              req_fire;
  logic              rsp_fire;
  logic              rsp_drop;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic [QW-1:0]     head;

  // Every word in flight already owns a queue slot, so the queue cannot overflow.
  assign credits        = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = ~reset & ~redirect & (credits < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a memory protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid & (outstanding != '0);
  assign rsp_drop = rsp_fire & (redirect | (drop != '0));
  assign push     = rsp_fire & ~rsp_drop & (~q_full | pop);
  assign pop      = instr_valid & instr_ready;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

  assign instr_valid = ~q_empty;
  assign instr_data  = q_empty ? '0 : head[QW-1:ADDR_W];
  assign instr_pc    = q_empty ? '0 : head[ADDR_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= ADDR_W'(RESET_PC);
      rsp_pc      <= ADDR_W'(RESET_PC);
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 1'b1;
        if (push)     rsp_pc   <= rsp_pc + 1'b1;
        if (rsp_fire && drop != '0) drop <= drop - 1'b1;
      end
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memory with configurable latency,
// a delivery monitor, and one task per scenario with inline checks.
module tb_fetch_unit;

  localparam int AW    = 16;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready = 1'b0;
  logic          imem_rsp_valid = 1'b0;
  logic [IW-1:0] imem_rsp_data  = '0;
  logic          instr_valid;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;
  logic          redirect    = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  // ---------------- memory model and monitor ----------------
  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   due;
  } mreq_t;

  mreq_t         mem_q[$];
  logic [AW-1:0] acc_q[$];
  int unsigned   acc_e[$];
  logic [AW-1:0] got_pc[$];
  logic [IW-1:0] got_data[$];
  int unsigned   got_e[$];
  logic [AW-1:0] exp_q[$];
  int unsigned   lat_min = 1;
  int unsigned   lat_max = 1;
  int unsigned   rdy_pct = 100;
  int unsigned   max_out = 0;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a ^ 16'hC35A) + 16'd1;
  endfunction

  // Drives the memory side for the coming edge (cyc is that edge's index),
  // then records request and decode handshakes once all inputs have settled.
  always @(negedge clock) begin
    #2;
    if (!reset && mem_q.size() > max_out) max_out = mem_q.size();
    imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (!reset && imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      acc_q.push_back(imem_req_addr);
      acc_e.push_back(cyc);
    end
    if (!reset && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
      got_e.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    mem_q.delete();
    acc_q.delete();
    acc_e.delete();
    got_pc.delete();
    got_data.delete();
    got_e.delete();
    exp_q.delete();
    max_out = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 16'h0000) begin
      $display("FAIL reset_req valid=%b addr=%h want valid=0 addr=0000", imem_req_valid, imem_req_addr);
    end else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b0 || instr_data !== 16'h0000 || instr_pc !== 16'h0000) begin
      $display("FAIL reset_instr valid=%b data=%h pc=%h want all 0", instr_valid, instr_data, instr_pc);
    end else n_pass++;
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    instr_ready = 1'b1;
    repeat (12) @(negedge clock);
    n_checks++;
    if (acc_q.size() < 8 || got_pc.size() < 6) begin
      $display("FAIL stream_count acc=%0d got=%0d want acc>=8 got>=6", acc_q.size(), got_pc.size());
    end else n_pass++;
    for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] !== AW'(i)) $display("FAIL stream_addr[%0d] got=%h want=%h", i, acc_q[i], AW'(i));
      else n_pass++;
    end
    for (int i = 0; i < 6 && i < got_pc.size(); i++) exp_q.push_back(AW'(i));
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_pc[i] !== exp_q[i] || got_data[i] !== mem_word(exp_q[i]))
        $display("FAIL stream_instr[%0d] pc=%h data=%h want pc=%h data=%h",
                 i, got_pc[i], got_data[i], exp_q[i], mem_word(exp_q[i]));
      else n_pass++;
      n_checks++;
      if (got_e[i] !== got_e[0] + i)
        $display("FAIL stream_rate[%0d] edge=%0d want=%0d", i, got_e[i], got_e[0] + i);
      else n_pass++;
    end
    if (got_e.size() > 0 && acc_e.size() > 0) begin
      n_checks++;
      if (got_e[0] - acc_e[0] !== 2)
        $display("FAIL stream_latency got=%0d want=2", got_e[0] - acc_e[0]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    repeat (10) @(negedge clock);
    n_checks++;
    if (acc_q.size() !== 4 || imem_req_valid !== 1'b0)
      $display("FAIL bp_stall requests=%0d req_valid=%b want 4 and 0", acc_q.size(), imem_req_valid);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== mem_word(16'h0000) || got_pc.size() !== 0)
      $display("FAIL bp_head valid=%b pc=%h data=%h pops=%0d want 1/0000/%h/0",
               instr_valid, instr_pc, instr_data, got_pc.size(), mem_word(16'h0000));
    else n_pass++;
    instr_ready = 1'b1;
    repeat (12) @(negedge clock);
    for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
    n_checks++;
    if (got_pc.size() < exp_q.size() || acc_q.size() < 5)
      $display("FAIL bp_drain_count got=%0d acc=%0d want >=6 and >=5", got_pc.size(), acc_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_pc.size(); i++) begin
      n_checks++;
      if (got_pc[i] !== exp_q[i] || got_data[i] !== mem_word(exp_q[i]))
        $display("FAIL bp_drain[%0d] pc=%h data=%h want pc=%h", i, got_pc[i], got_data[i], exp_q[i]);
      else n_pass++;
    end
    if (acc_q.size() > 4) begin
      n_checks++;
      if (acc_q[4] !== 16'h0004) $display("FAIL bp_resume addr=%h want=0004", acc_q[4]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    repeat (6) @(negedge clock);
    reset = 1'b1;
    mem_q.delete();
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 16'h0000 || instr_pc !== 16'h0000)
      $display("FAIL reset_mid ivalid=%b rvalid=%b addr=%h pc=%h want 0/0/0000/0000",
               instr_valid, imem_req_valid, imem_req_addr, instr_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    lat_min = 3; lat_max = 3; rdy_pct = 100;
    do_reset();
    instr_ready = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (mem_q.size() !== 2) $display("FAIL redir_inflight outstanding=%0d want=2", mem_q.size());
    else n_pass++;
    redirect = 1'b1; redirect_pc = 16'h0040;
    @(negedge clock);
    redirect = 1'b0;
    repeat (12) @(negedge clock);
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0040 + AW'(i));
    n_checks++;
    if (got_pc.size() < exp_q.size() || acc_q.size() < 3)
      $display("FAIL redir_count got=%0d acc=%0d want >=5 and >=3", got_pc.size(), acc_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_pc.size(); i++) begin
      n_checks++;
      if (got_pc[i] !== exp_q[i] || got_data[i] !== mem_word(exp_q[i]))
        $display("FAIL redir_instr[%0d] pc=%h data=%h want pc=%h", i, got_pc[i], got_data[i], exp_q[i]);
      else n_pass++;
    end
    if (acc_q.size() > 2) begin
      n_checks++;
      if (acc_q[2] !== 16'h0040) $display("FAIL redir_addr got=%h want=0040", acc_q[2]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    lat_min = 2; lat_max = 2; rdy_pct = 100;
    do_reset();
    instr_ready = 1'b1;
    repeat (2) @(negedge clock);
    redirect = 1'b1; redirect_pc = 16'h0080;
    @(negedge clock);
    redirect_pc = 16'h0100;
    @(negedge clock);
    redirect = 1'b0;
    repeat (14) @(negedge clock);
    for (int i = 0; i < 6; i++) exp_q.push_back(16'h0100 + AW'(i));
    n_checks++;
    if (acc_q.size() < 4 || acc_q[0] !== 16'h0000 || acc_q[1] !== 16'h0001 ||
        acc_q[2] !== 16'h0100 || acc_q[3] !== 16'h0101)
      $display("FAIL b2b_addrs n=%0d first four %h %h %h %h want 0000 0001 0100 0101", acc_q.size(),
               acc_q.size() > 0 ? acc_q[0] : 16'hxxxx, acc_q.size() > 1 ? acc_q[1] : 16'hxxxx,
               acc_q.size() > 2 ? acc_q[2] : 16'hxxxx, acc_q.size() > 3 ? acc_q[3] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (got_pc.size() < exp_q.size()) $display("FAIL b2b_count got=%0d want>=6", got_pc.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_pc.size(); i++) begin
      n_checks++;
      if (got_pc[i] !== exp_q[i] || got_data[i] !== mem_word(exp_q[i]))
        $display("FAIL b2b_instr[%0d] pc=%h data=%h want pc=%h", i, got_pc[i], got_data[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clock);
    redirect = 1'b0;
    repeat (10) @(negedge clock);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    n_checks++;
    if (acc_q.size() < 3 || got_pc.size() < 3)
      $display("FAIL wrap_count acc=%0d got=%0d want >=3", acc_q.size(), got_pc.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] !== exp_q[i]) $display("FAIL wrap_addr[%0d] got=%h want=%h", i, acc_q[i], exp_q[i]);
      else n_pass++;
    end
    for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
      n_checks++;
      if (got_pc[i] !== exp_q[i] || got_data[i] !== mem_word(exp_q[i]))
        $display("FAIL wrap_instr[%0d] pc=%h data=%h want pc=%h", i, got_pc[i], got_data[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] tgt;
    logic          redir;
    int            delivered;
    lat_min = 1; lat_max = 4; rdy_pct = 60;
    do_reset();
    exp_pc    = 16'h0000;
    delivered = 0;
    for (int c = 0; c < 340; c++) begin
      redir       = (c < 300) && ($urandom_range(19, 0) == 0);
      tgt         = AW'($urandom_range(16'hFFFF, 0));
      instr_ready = (c >= 300) || ($urandom_range(99, 0) < 70);
      redirect    = redir;
      redirect_pc = tgt;
      if (c == 300) rdy_pct = 100;
      @(posedge clock);
      while (got_pc.size() > 0) begin
        n_checks++;
        if (got_pc[0] !== exp_pc || got_data[0] !== mem_word(exp_pc))
          $display("FAIL rand_instr[%0d] pc=%h data=%h want pc=%h data=%h",
                   delivered, got_pc[0], got_data[0], exp_pc, mem_word(exp_pc));
        else n_pass++;
        void'(got_pc.pop_front());
        void'(got_data.pop_front());
        exp_pc = exp_pc + 1'b1;
        delivered++;
      end
      if (redir) exp_pc = tgt;
      @(negedge clock);
    end
    redirect = 1'b0;
    n_checks++;
    if (delivered < 40) $display("FAIL rand_progress delivered=%0d want>=40", delivered);
    else n_pass++;
    n_checks++;
    if (max_out > DEPTH) $display("FAIL rand_credits max_outstanding=%0d want<=%0d", max_out, DEPTH);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_redirect_inflight();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
